// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared widths, state encoding and halt marker for the program loader
package instr_mem_loader_pkg;

    localparam int WIDTH_B_DEF = 32;
    localparam int ADDR_B_DEF  = 10;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - byte stream, instruction memory write port and CPU hold/status bundle
interface instr_mem_loader_if
    import instr_mem_loader_pkg::*;
#(
    parameter int width_B = WIDTH_B_DEF,
    parameter int Addr_B  = ADDR_B_DEF
);
    logic               start;
    logic [7:0]         byte_in;
    logic               byte_valid;
    logic               byte_ready;
    logic               mem_we;
    logic [Addr_B-1:0]  mem_addr;
    logic [width_B-1:0] mem_din;
    logic               cpu_hold;
    logic               done;
    logic [Addr_B:0]    word_count;

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_din, cpu_hold, done, word_count
    );

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_din, cpu_hold, done, word_count
    );

endinterface

// File: rtl/instr_mem_loader_byte_packer.sv
// rtl/instr_mem_loader_byte_packer.sv - packs accepted bytes MSB-first into one instruction word
module instr_mem_loader_byte_packer
    import instr_mem_loader_pkg::*;
#(
    parameter int width_B = WIDTH_B_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_shift,
    input  logic [7:0]         i_byte,
    output logic [width_B-1:0] o_word,
    output logic               o_word_ready
);

    localparam int NB = bytes_per_word(width_B);
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    // Only the older bytes need storage; the final byte is taken straight from the input.
    logic [width_B-9:0] r_shift;
    logic [IW-1:0]      r_idx;

    assign o_word       = {r_shift, i_byte};
    assign o_word_ready = i_shift && (r_idx == IW'(NB - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_shift) begin
            r_shift <= o_word[width_B-9:0];
            r_idx   <= o_word_ready ? '0 : r_idx + IW'(1);
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - loads a byte stream into instruction memory from address 0 while stalling the CPU
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int width_B = WIDTH_B_DEF,
    parameter int Addr_B  = ADDR_B_DEF,
    parameter logic [width_B-1:0] HALT_WORD = width_B'(HALT_WORD_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    instr_mem_loader_if.slave  bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [Addr_B-1:0]  r_addr;
    logic [Addr_B-1:0]  r_mem_addr;
    logic [width_B-1:0] r_mem_din;
    logic [Addr_B:0]    r_word_count;
    logic               r_mem_we;
    logic               r_cpu_hold;
    logic               r_done;

    logic               w_byte_ready;
    logic               w_accept;
    logic               w_load_start;
    logic               w_word_ready;
    logic               w_last_addr;
    logic               w_halt;
    logic               w_we_d;
    logic               w_hold_d;
    logic               w_done_d;
    logic [width_B-1:0] w_word;

    assign w_accept     = bus.byte_valid && w_byte_ready;
    assign w_load_start = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last_addr  = (r_addr == {Addr_B{1'b1}});
    assign w_halt       = (r_mem_din == HALT_WORD);

    instr_mem_loader_byte_packer #(
        .width_B (width_B)
    ) u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_load_start),
        .i_shift      (w_accept),
        .i_byte       (bus.byte_in),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_load_start) w_state_nxt = S_RECV;
            S_RECV:  if (w_word_ready) w_state_nxt = S_WRITE;
            // Full memory ends the load rather than wrapping onto address 0.
            S_WRITE: w_state_nxt = (w_halt || w_last_addr) ? S_DONE : S_RECV;
            S_DONE:  if (w_load_start) w_state_nxt = S_RECV;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_byte_ready = (r_state == S_RECV);
        w_we_d       = (w_state_nxt == S_WRITE);
        w_hold_d     = (w_state_nxt == S_RECV) || (w_state_nxt == S_WRITE);
        w_done_d     = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_word_count <= '0;
            r_mem_we     <= 1'b0;
            r_cpu_hold   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mem_we   <= w_we_d;
            r_cpu_hold <= w_hold_d;
            r_done     <= w_done_d;
            if (w_load_start) begin
                r_addr       <= '0;
                r_word_count <= '0;
            end
            if (w_word_ready) begin
                r_mem_addr <= r_addr;
                r_mem_din  <= w_word;
            end
            if (r_state == S_WRITE) begin
                r_word_count <= r_word_count + (Addr_B + 1)'(1);
                if (w_state_nxt == S_RECV)
                    r_addr <= r_addr + Addr_B'(1);
            end
        end
    end

    assign bus.byte_ready = w_byte_ready;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_din    = r_mem_din;
    assign bus.cpu_hold   = r_cpu_hold;
    assign bus.done       = r_done;
    assign bus.word_count = r_word_count;

endmodule
